imem_fetch_responder: RTL

Instruction-memory responder that services fetch requests issued from the program-counter side of the datapath. It accepts one 32-bit byte address per handshake, reads a word-addressed instruction store and returns the instruction after a programmable fixed latency over a valid/ready handshake. It sits between the PC/next-PC logic (initiator) and the instruction register/decode stage (response consumer). A side load port fills the store from the bench or boot logic.

---
 rtl/imem_fetch_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
//   Instruction-memory responder for the fetch path. Accepts one byte
//   address per request handshake, reads a word-addressed instruction
//   store at the accept edge and presents the word LATENCY cycles later
//   on a valid/ready response channel. Only one fetch is in flight at a
//   time. A side load port writes the store in any state.
//
// Parameters
//   DEPTH   : words in the store (power of two, 2..65536)
//   LATENCY : cycles from accept edge to resp_valid (1..15)
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_ready : fetch request handshake
//   req_addr            : byte address of the instruction
//   resp_valid/ready    : response handshake
//   resp_data           : fetched word (0 on error)
//   resp_addr           : echo of the accepted request address
//   resp_err            : misaligned or out-of-range fetch
//   load_en/addr/data   : store write port (word index)
module imem_fetch_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2,
  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_data,
  output logic [31:0]   resp_addr,
  output logic          resp_err,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  // Counter preload. Every accept passes through WAIT for LATENCY cycles,
  // which keeps accept-to-valid at exactly LATENCY edges for all values,
  // including LATENCY=1.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0] mem [DEPTH];

  state_t      state_q,      state_d;
  logic [3:0]  cnt_q,        cnt_d;
  logic        req_ready_q,  req_ready_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_data_q,  resp_data_d;
  logic [31:0] resp_addr_q,  resp_addr_d;
  logic        resp_err_q,   resp_err_d;

  logic [AW-1:0] req_idx;
  logic          req_bad;

  // Misaligned, or word index beyond the store (any address bit above the
  // index field set).
  function automatic logic fetch_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  assign req_idx = req_addr[AW+1:2];
  assign req_bad = fetch_err(req_addr);

  // Store write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_addr_d  = resp_addr_q;
    resp_err_d   = resp_err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          // Data captured here, so later loads cannot disturb this fetch;
          // a load on this same edge is not yet visible (old word read).
          resp_addr_d = req_addr;
          resp_err_d  = req_bad;
          resp_data_d = req_bad ? 32'h0 : mem[req_idx];
          cnt_d       = CNT_INIT;
          req_ready_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_addr_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_addr_q  <= resp_addr_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_addr  = resp_addr_q;
  assign resp_err   = resp_err_q;

endmodule
